// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared data-memory constants, requester owner codes and request record
package riscv_mem_pkg;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DMA = 1'b1;
  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: counts consecutive DMA wait cycles and raises force_dma at the limit
module dmem_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_dma
);
  logic [3:0] cnt;
  // saturating wait counter, cleared whenever DMA is served or stops asking
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (!dma_req || dma_gnt) cnt <= '0;
    else if (cnt != 4'(LIMIT)) cnt <= cnt + 4'd1;
  assign force_dma = dma_req && cnt == 4'(LIMIT);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core-priority data-memory arbiter with DMA anti-starvation; DMEM_ARB_STATS_EN adds grant/conflict counters
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   core_grant_cnt,
  output logic [31:0]   dma_grant_cnt,
  output logic [31:0]   conflict_cnt
`endif
);
  logic force_dma, acc_valid, acc_we, acc_owner, any_gnt;
  dmem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk), .reset(reset), .dma_req(dma_req), .dma_gnt(dma_gnt), .force_dma(force_dma)
  );
  // fixed core priority unless DMA has waited long enough; nothing is granted while in reset
  always_comb begin
    dma_gnt = !reset && dma_req && (force_dma || !core_req);
    core_gnt = !reset && core_req && !force_dma;
    any_gnt = core_gnt || dma_gnt;
  end
  assign core_stall = core_req && !core_gnt;
  assign mem_write = acc_valid && acc_we;
  assign mem_read = acc_valid && !acc_we;
  // access stage: latch the winner; address/data hold when idle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc_valid <= 1'b0;
      acc_we <= 1'b0;
      acc_owner <= OWNER_CORE;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      acc_valid <= any_gnt;
      if (any_gnt) begin
        acc_we <= dma_gnt ? dma_we : core_we;
        acc_owner <= dma_gnt ? OWNER_DMA : OWNER_CORE;
        mem_addr <= dma_gnt ? dma_addr : core_addr;
        mem_wdata <= dma_gnt ? dma_wdata : core_wdata;
      end
    end
  // response stage: capture read data for the owner and pulse its rvalid
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      core_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      core_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      core_rvalid <= mem_read && acc_owner == OWNER_CORE;
      dma_rvalid <= mem_read && acc_owner == OWNER_DMA;
      if (mem_read && acc_owner == OWNER_CORE) core_rdata <= mem_rdata;
      if (mem_read && acc_owner == OWNER_DMA) dma_rdata <= mem_rdata;
    end
`ifdef DMEM_ARB_STATS_EN
  // free-running wrap-around usage counters
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      core_grant_cnt <= '0;
      dma_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      core_grant_cnt <= core_grant_cnt + 32'(core_gnt);
      dma_grant_cnt <= dma_grant_cnt + 32'(dma_gnt);
      conflict_cnt <= conflict_cnt + 32'(core_req && dma_req);
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, reset/stats sequences and randomized run against a timeline model
module tb_dmem_arbiter;
  localparam int LIM = 4;
  localparam int NR = 600;
  logic clk = 1'b0, reset = 1'b1;
  logic core_req = 0, core_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic core_gnt, core_stall, core_rvalid, dma_gnt, dma_rvalid, mem_read, mem_write;
  logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] core_grant_cnt, dma_grant_cnt, conflict_cnt;
`endif
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int checks = 0, errors = 0;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .core_grant_cnt(core_grant_cnt), .dma_grant_cnt(dma_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    logic cr, cwe; logic [31:0] ca, cwd;
    logic dr, dwe; logic [31:0] da, dwd;
    logic cg, dg, mw, mr; logic [31:0] ma;
    logic crv; logic [31:0] crd;
    logic drv; logic [31:0] drd;
  } vec_t;

  typedef struct packed {
    logic v, o, we;
    logic [31:0] a, d;
  } g_t;

  function automatic vec_t v(input logic cr, cwe, input logic [31:0] ca, cwd,
                             input logic dr, dwe, input logic [31:0] da, dwd,
                             input logic cg, dg, mw, mr, input logic [31:0] ma,
                             input logic crv, input logic [31:0] crd,
                             input logic drv, input logic [31:0] drd);
    vec_t r;
    r.cr = cr; r.cwe = cwe; r.ca = ca; r.cwd = cwd;
    r.dr = dr; r.dwe = dwe; r.da = da; r.dwd = dwd;
    r.cg = cg; r.dg = dg; r.mw = mw; r.mr = mr; r.ma = ma;
    r.crv = crv; r.crd = crd; r.drv = drv; r.drd = drd;
    return r;
  endfunction

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", n, act, exp, $time);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, cwe, input logic [31:0] ca, cwd,
                       input logic dr, dwe, input logic [31:0] da, dwd);
    core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cwd;
    dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
  endtask

  task automatic mem_init();
    for (int i = 0; i < 64; i++) begin
      mem[i] <= 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[0] <= 32'hA0; mem[1] <= 32'hA1; mem[2] <= 32'hA2;
    mem[8] <= 32'h12345678; mem[16] <= 32'h0BADF00D;
    ref_mem[0] = 32'hA0; ref_mem[1] = 32'hA1; ref_mem[2] = 32'hA2;
    ref_mem[8] = 32'h12345678; ref_mem[16] = 32'h0BADF00D;
  endtask

  initial begin
    vec_t tbl [26];
    g_t hist [NR + 24];
    logic [31:0] rdv [NR + 24];
    logic [31:0] lrd [2];
    logic cp, dp, eg_c, eg_d;
    g_t a, r;
    int w;
    localparam logic [31:0] DB = 32'hDEADBEEF, P = 32'h12345678;
    tbl[0]  = v(1,1,32'h10,DB, 0,0,0,0, 1,0,0,0,0,       0,0,    0,0);
    tbl[1]  = v(1,0,32'h10,0,  0,0,0,0, 1,0,1,0,32'h10,  0,0,    0,0);
    tbl[2]  = v(0,0,0,0,       0,0,0,0, 0,0,0,1,32'h10,  0,0,    0,0);
    tbl[3]  = v(0,0,0,0,       0,0,0,0, 0,0,0,0,0,       1,DB,   0,0);
    tbl[4]  = v(0,0,0,0,       1,0,32'h20,0, 0,1,0,0,0,  0,DB,   0,0);
    tbl[5]  = v(0,0,0,0,       0,0,0,0, 0,0,0,1,32'h20,  0,DB,   0,0);
    tbl[6]  = v(0,0,0,0,       0,0,0,0, 0,0,0,0,0,       0,DB,   1,P);
    tbl[7]  = v(1,0,32'h0,0,   0,0,0,0, 1,0,0,0,0,       0,DB,   0,P);
    tbl[8]  = v(1,0,32'h4,0,   0,0,0,0, 1,0,0,1,32'h0,   0,DB,   0,P);
    tbl[9]  = v(1,0,32'h8,0,   0,0,0,0, 1,0,0,1,32'h4,   1,32'hA0, 0,P);
    tbl[10] = v(0,0,0,0,       0,0,0,0, 0,0,0,1,32'h8,   1,32'hA1, 0,P);
    tbl[11] = v(0,0,0,0,       0,0,0,0, 0,0,0,0,0,       1,32'hA2, 0,P);
    tbl[12] = v(0,0,0,0,       0,0,0,0, 0,0,0,0,0,       0,32'hA2, 0,P);
    tbl[13] = v(1,0,0,0, 1,0,32'h20,0, 1,0,0,0,0,        0,32'hA2, 0,P);
    tbl[14] = v(1,0,0,0, 1,0,32'h20,0, 1,0,0,1,0,        0,32'hA2, 0,P);
    tbl[15] = v(1,0,0,0, 1,0,32'h20,0, 1,0,0,1,0,        1,32'hA0, 0,P);
    tbl[16] = v(1,0,0,0, 1,0,32'h20,0, 1,0,0,1,0,        1,32'hA0, 0,P);
    tbl[17] = v(1,0,0,0, 1,0,32'h20,0, 0,1,0,1,0,        1,32'hA0, 0,P);
    tbl[18] = v(1,0,0,0, 1,0,32'h20,0, 1,0,0,1,32'h20,   1,32'hA0, 0,P);
    tbl[19] = v(1,0,0,0, 1,0,32'h20,0, 1,0,0,1,0,        0,32'hA0, 1,P);
    tbl[20] = v(1,0,0,0, 1,0,32'h20,0, 1,0,0,1,0,        1,32'hA0, 0,P);
    tbl[21] = v(1,0,0,0, 1,0,32'h20,0, 1,0,0,1,0,        1,32'hA0, 0,P);
    tbl[22] = v(1,0,0,0, 1,0,32'h20,0, 0,1,0,1,0,        1,32'hA0, 0,P);
    tbl[23] = v(0,0,0,0,       0,0,0,0, 0,0,0,1,32'h20,  1,32'hA0, 0,P);
    tbl[24] = v(0,0,0,0,       0,0,0,0, 0,0,0,0,0,       0,32'hA0, 1,P);
    tbl[25] = v(0,0,0,0,       0,0,0,0, 0,0,0,0,0,       0,32'hA0, 0,P);
    mem_init();
    repeat (2) @(negedge clk);
    #1;
    chk1("reset_core_gnt", core_gnt, 1'b0);
    chk1("reset_mem_read", mem_read, 1'b0);
    chk1("reset_mem_write", mem_write, 1'b0);
    chk32("reset_mem_addr", mem_addr, 32'h0);
    chk32("reset_core_rdata", core_rdata, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i].cr, tbl[i].cwe, tbl[i].ca, tbl[i].cwd, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd);
      #2;
      chk1($sformatf("v%0d core_gnt", i), core_gnt, tbl[i].cg);
      chk1($sformatf("v%0d dma_gnt", i), dma_gnt, tbl[i].dg);
      chk1($sformatf("v%0d core_stall", i), core_stall, tbl[i].cr & ~tbl[i].cg);
      chk1($sformatf("v%0d mem_write", i), mem_write, tbl[i].mw);
      chk1($sformatf("v%0d mem_read", i), mem_read, tbl[i].mr);
      if (tbl[i].mw || tbl[i].mr) chk32($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].ma);
      chk1($sformatf("v%0d core_rvalid", i), core_rvalid, tbl[i].crv);
      chk32($sformatf("v%0d core_rdata", i), core_rdata, tbl[i].crd);
      chk1($sformatf("v%0d dma_rvalid", i), dma_rvalid, tbl[i].drv);
      chk32($sformatf("v%0d dma_rdata", i), dma_rdata, tbl[i].drd);
    end
    chk32("store_committed", mem[4], DB);
    @(negedge clk);
    drive(1, 1, 32'h40, 32'h55555555, 0, 0, 0, 0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk1("rst_pre_mem_write", mem_write, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_core_rdata", core_rdata, 32'h0);
    chk32("rst_dma_rdata", dma_rdata, 32'h0);
    chk1("rst_core_rvalid", core_rvalid, 1'b0);
    @(posedge clk);
    #1 chk32("rst_mem40_kept", mem[16], 32'h0BADF00D);
    @(negedge clk);
    reset = 1'b0;
`ifdef DMEM_ARB_STATS_EN
    repeat (10) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 1, 0, 32'h20, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk32("stats_conflict", conflict_cnt, 32'd10);
    chk32("stats_core", core_grant_cnt, 32'd8);
    chk32("stats_dma", dma_grant_cnt, 32'd2);
`endif
    @(negedge clk);
    reset = 1'b1;
    mem_init();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR + 24; i++) begin
      hist[i] = '0;
      rdv[i] = '0;
    end
    lrd[0] = 0; lrd[1] = 0;
    cp = 0; dp = 0; w = 0;
    for (int t = 2; t < NR + 22; t++) begin
      @(negedge clk);
      if (!cp && t < NR && $urandom_range(99) < 70) begin
        cp = 1; core_we = 1'($urandom_range(1)); core_addr = 32'($urandom_range(255)); core_wdata = $urandom;
      end
      if (!dp && t < NR && $urandom_range(99) < 45) begin
        dp = 1; dma_we = 1'($urandom_range(1)); dma_addr = 32'($urandom_range(255)); dma_wdata = $urandom;
      end
      core_req = cp; dma_req = dp;
      #2;
      eg_d = dp && (w >= LIM || !cp);
      eg_c = cp && !eg_d;
      hist[t] = {eg_c | eg_d, eg_d, eg_d ? dma_we : core_we,
                 eg_d ? dma_addr : core_addr, eg_d ? dma_wdata : core_wdata};
      a = hist[t-1];
      if (a.v && !a.we) rdv[t-1] = ref_mem[a.a[7:2]];
      r = hist[t-2];
      if (r.v && !r.we) lrd[r.o] = rdv[t-2];
      chk1("rnd core_gnt", core_gnt, eg_c);
      chk1("rnd dma_gnt", dma_gnt, eg_d);
      chk1("rnd mem_write", mem_write, a.v && a.we);
      chk1("rnd mem_read", mem_read, a.v && !a.we);
      if (a.v) chk32("rnd mem_addr", mem_addr, a.a);
      if (a.v && a.we) chk32("rnd mem_wdata", mem_wdata, a.d);
      chk1("rnd core_rvalid", core_rvalid, r.v && !r.we && !r.o);
      chk1("rnd dma_rvalid", dma_rvalid, r.v && !r.we && r.o);
      chk32("rnd core_rdata", core_rdata, lrd[0]);
      chk32("rnd dma_rdata", dma_rdata, lrd[1]);
      if (a.v && a.we) ref_mem[a.a[7:2]] = a.d;
      w = (dp && !eg_d) ? (w < LIM ? w + 1 : LIM) : 0;
      if (eg_c) cp = 0;
      if (eg_d) dp = 0;
    end
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk32($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
